neuron_a_bwd: RTL and testbench

Backward-pass (training) counterpart of the forward `neuron_a` datapath, which computes y = tanh(Σ(a_i·w_i + b_i)). Given the cached forward activations, forward output y, incoming error dL/dy and learning rate, it computes:

- delta = err_in·(1 − y²);
- updated weights w_i − lr·delta·a_i;
- updated biases b_i − lr·delta;
- the error propagated to the previous layer, delta·w_i.

One shared signed fixed-point multiplier is time-multiplexed by an FSM. Valid/ready handshakes on both input and output let the block sit between the layer-error producer and the weight store.

---
 rtl/neuron_a_bwd.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_neuron_a_bwd.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_a_bwd.sv
// ---------------------------------------------------------------------------
// neuron_a_bwd
//   Backward pass of a 3-input tanh neuron. From the cached forward
//   activations a_i, the forward output y, the incoming error dL/dy (err_in)
//   and the learning rate lr it produces:
//     delta     = err_in * (1 - y^2)      (1 - y^2 clamped at 0)
//     w_new_i   = w_i - lr*delta*a_i
//     b_new_i   = b_i - lr*delta
//     err_out_i = delta * w_i             (old weights)
//   A single signed fixed-point multiplier is shared across nine compute
//   cycles by a small FSM. All arithmetic is Q(WIDTH-FRAC).FRAC, saturating.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready = idle)
//   a_*, w_*, b_*         activations, weights, biases
//   y, err_in, lr         forward output, dL/dy, learning rate
//   out_valid / out_ready result handshake (out_valid = results held)
//   w_new_*, b_new_*      updated weights / biases
//   err_out_*             error propagated to the previous layer
//   sat                   some clamp fired during the current transaction
// ---------------------------------------------------------------------------
module neuron_a_bwd #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a_1,
  input  logic signed [WIDTH-1:0] a_2,
  input  logic signed [WIDTH-1:0] a_3,
  input  logic signed [WIDTH-1:0] w_1,
  input  logic signed [WIDTH-1:0] w_2,
  input  logic signed [WIDTH-1:0] w_3,
  input  logic signed [WIDTH-1:0] b_1,
  input  logic signed [WIDTH-1:0] b_2,
  input  logic signed [WIDTH-1:0] b_3,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] err_in,
  input  logic signed [WIDTH-1:0] lr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] w_new_1,
  output logic signed [WIDTH-1:0] w_new_2,
  output logic signed [WIDTH-1:0] w_new_3,
  output logic signed [WIDTH-1:0] b_new_1,
  output logic signed [WIDTH-1:0] b_new_2,
  output logic signed [WIDTH-1:0] b_new_3,
  output logic signed [WIDTH-1:0] err_out_1,
  output logic signed [WIDTH-1:0] err_out_2,
  output logic signed [WIDTH-1:0] err_out_3,
  output logic                    sat
);

  localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1) << FRAC;
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, D1, D2, LD, G1, E1, G2, E2, G3, E3, DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Captured operands
  logic signed [WIDTH-1:0] r_a [3];
  logic signed [WIDTH-1:0] r_w [3];
  logic signed [WIDTH-1:0] r_b [3];
  logic signed [WIDTH-1:0] r_y;
  logic signed [WIDTH-1:0] r_err;
  logic signed [WIDTH-1:0] r_lr;

  // Intermediates
  logic signed [WIDTH-1:0] r_t;
  logic signed [WIDTH-1:0] r_delta;
  logic signed [WIDTH-1:0] r_ld;

  // Result registers
  logic signed [WIDTH-1:0] r_w_new   [3];
  logic signed [WIDTH-1:0] r_b_new   [3];
  logic signed [WIDTH-1:0] r_err_out [3];
  logic                    r_sat;

  // -------------------------------------------------------------------------
  // FSM: state register + next-state logic
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = D1;
      D1:      w_state_next = D2;
      D2:      w_state_next = LD;
      LD:      w_state_next = G1;
      G1:      w_state_next = E1;
      E1:      w_state_next = G2;
      G2:      w_state_next = E2;
      E2:      w_state_next = G3;
      G3:      w_state_next = E3;
      E3:      w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Handshake flags are pure decodes of the state register.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  // -------------------------------------------------------------------------
  // Shared multiplier operand selection
  // -------------------------------------------------------------------------
  logic [1:0]              w_lane;
  logic                    w_is_g;
  logic                    w_is_e;
  logic signed [WIDTH-1:0] w_one_minus_t;
  logic signed [WIDTH-1:0] w_mx;
  logic signed [WIDTH-1:0] w_mz;

  // y^2 above 1.0 means 1 - y^2 would be negative; tanh' is never negative,
  // so it is pinned at 0. This is a modelling clamp, not an overflow, so it
  // does not raise sat.
  assign w_one_minus_t = (r_t > ONE) ? '0 : (ONE - r_t);

  always_comb begin
    w_lane = 2'd0;
    w_is_g = 1'b0;
    w_is_e = 1'b0;
    case (r_state)
      G1: begin w_lane = 2'd0; w_is_g = 1'b1; end
      E1: begin w_lane = 2'd0; w_is_e = 1'b1; end
      G2: begin w_lane = 2'd1; w_is_g = 1'b1; end
      E2: begin w_lane = 2'd1; w_is_e = 1'b1; end
      G3: begin w_lane = 2'd2; w_is_g = 1'b1; end
      E3: begin w_lane = 2'd2; w_is_e = 1'b1; end
      default: begin end
    endcase
  end

  always_comb begin
    w_mx = '0;
    w_mz = '0;
    case (r_state)
      D1: begin w_mx = r_y;   w_mz = r_y;           end
      D2: begin w_mx = r_err; w_mz = w_one_minus_t; end
      LD: begin w_mx = r_lr;  w_mz = r_delta;       end
      default: begin
        if (w_is_g) begin
          w_mx = r_ld;
          w_mz = r_a[w_lane];
        end else if (w_is_e) begin
          w_mx = r_delta;
          w_mz = r_w[w_lane];
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Multiplier: full-width product, arithmetic shift (floor), saturate.
  // Operands default to 0 outside compute states, so w_mul_sat is only ever
  // high while a real multiply is in flight.
  // -------------------------------------------------------------------------
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [2*WIDTH-1:0] w_shift;
  logic                      w_mul_sat;
  logic signed [WIDTH-1:0]   w_mul_res;

  assign w_prod  = $signed({{WIDTH{w_mx[WIDTH-1]}}, w_mx})
                 * $signed({{WIDTH{w_mz[WIDTH-1]}}, w_mz});
  assign w_shift = w_prod >>> FRAC;

  // The result fits when every bit from WIDTH-1 upward is a sign copy.
  assign w_mul_sat = !((&w_shift[2*WIDTH-1:WIDTH-1]) ||
                       !(|w_shift[2*WIDTH-1:WIDTH-1]));
  assign w_mul_res = w_mul_sat ? (w_shift[2*WIDTH-1] ? MINV : MAXV)
                               : w_shift[WIDTH-1:0];

  // -------------------------------------------------------------------------
  // Saturating subtractors: three bias lanes in parallel (all updated in LD),
  // one weight lane shared across G1..G3.
  // -------------------------------------------------------------------------
  logic signed [WIDTH:0]   w_bdiff [3];
  logic signed [WIDTH-1:0] w_bres  [3];
  logic [2:0]              w_bsat;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_bsub
      assign w_bdiff[gi] = {r_b[gi][WIDTH-1], r_b[gi]}
                         - {w_mul_res[WIDTH-1], w_mul_res};
      assign w_bsat[gi]  = w_bdiff[gi][WIDTH] ^ w_bdiff[gi][WIDTH-1];
      assign w_bres[gi]  = w_bsat[gi] ? (w_bdiff[gi][WIDTH] ? MINV : MAXV)
                                      : w_bdiff[gi][WIDTH-1:0];
    end
  endgenerate

  logic signed [WIDTH:0]   w_wdiff;
  logic                    w_wsat;
  logic signed [WIDTH-1:0] w_wres;

  assign w_wdiff = {r_w[w_lane][WIDTH-1], r_w[w_lane]}
                 - {w_mul_res[WIDTH-1], w_mul_res};
  assign w_wsat  = w_wdiff[WIDTH] ^ w_wdiff[WIDTH-1];
  assign w_wres  = w_wsat ? (w_wdiff[WIDTH] ? MINV : MAXV)
                          : w_wdiff[WIDTH-1:0];

  // Any clamp that fires in the current cycle.
  logic w_step_sat;
  assign w_step_sat = w_mul_sat
                    | ((r_state == LD) & (|w_bsat))
                    | (w_is_g & w_wsat);

  // -------------------------------------------------------------------------
  // Datapath registers. Each result register is written only in its own
  // state and otherwise holds, so results survive DONE -> IDLE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_a[i]       <= '0;
        r_w[i]       <= '0;
        r_b[i]       <= '0;
        r_w_new[i]   <= '0;
        r_b_new[i]   <= '0;
        r_err_out[i] <= '0;
      end
      r_y     <= '0;
      r_err   <= '0;
      r_lr    <= '0;
      r_t     <= '0;
      r_delta <= '0;
      r_ld    <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a[0] <= a_1;  r_a[1] <= a_2;  r_a[2] <= a_3;
            r_w[0] <= w_1;  r_w[1] <= w_2;  r_w[2] <= w_3;
            r_b[0] <= b_1;  r_b[1] <= b_2;  r_b[2] <= b_3;
            r_y    <= y;
            r_err  <= err_in;
            r_lr   <= lr;
            r_sat  <= 1'b0;
          end
        end
        D1: begin
          r_t   <= w_mul_res;
          r_sat <= r_sat | w_step_sat;
        end
        D2: begin
          r_delta <= w_mul_res;
          r_sat   <= r_sat | w_step_sat;
        end
        LD: begin
          r_ld <= w_mul_res;
          for (int i = 0; i < 3; i++) begin
            r_b_new[i] <= w_bres[i];
          end
          r_sat <= r_sat | w_step_sat;
        end
        G1, G2, G3: begin
          r_w_new[w_lane] <= w_wres;
          r_sat           <= r_sat | w_step_sat;
        end
        E1, E2, E3: begin
          r_err_out[w_lane] <= w_mul_res;
          r_sat             <= r_sat | w_step_sat;
        end
        default: begin end
      endcase
    end
  end

  assign w_new_1   = r_w_new[0];
  assign w_new_2   = r_w_new[1];
  assign w_new_3   = r_w_new[2];
  assign b_new_1   = r_b_new[0];
  assign b_new_2   = r_b_new[1];
  assign b_new_3   = r_b_new[2];
  assign err_out_1 = r_err_out[0];
  assign err_out_2 = r_err_out[1];
  assign err_out_3 = r_err_out[2];
  assign sat       = r_sat;

endmodule

// File: tb/tb_neuron_a_bwd.sv
// ---------------------------------------------------------------------------
// tb_neuron_a_bwd
//   Directed-vector bench for neuron_a_bwd with hand-computed Q16.16
//   expectations. One line per transaction, one summary line at the end.
// ---------------------------------------------------------------------------
module tb_neuron_a_bwd;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic signed [31:0] a_1, a_2, a_3, w_1, w_2, w_3, b_1, b_2, b_3;
  logic signed [31:0] y, err_in, lr;
  logic out_valid;
  logic out_ready;
  logic signed [31:0] w_new_1, w_new_2, w_new_3;
  logic signed [31:0] b_new_1, b_new_2, b_new_3;
  logic signed [31:0] err_out_1, err_out_2, err_out_3;
  logic sat;

  int n_tests = 0;
  int n_fail  = 0;

  neuron_a_bwd #(.WIDTH(32), .FRAC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_1       (a_1),
    .a_2       (a_2),
    .a_3       (a_3),
    .w_1       (w_1),
    .w_2       (w_2),
    .w_3       (w_3),
    .b_1       (b_1),
    .b_2       (b_2),
    .b_3       (b_3),
    .y         (y),
    .err_in    (err_in),
    .lr        (lr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .w_new_1   (w_new_1),
    .w_new_2   (w_new_2),
    .w_new_3   (w_new_3),
    .b_new_1   (b_new_1),
    .b_new_2   (b_new_2),
    .b_new_3   (b_new_3),
    .err_out_1 (err_out_1),
    .err_out_2 (err_out_2),
    .err_out_3 (err_out_3),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [31:0] yv, ev, lv,
                       input logic [31:0] a1, a2, a3,
                       input logic [31:0] w1v, w2v, w3v,
                       input logic [31:0] b1v, b2v, b3v);
    y = yv; err_in = ev; lr = lv;
    a_1 = a1; a_2 = a2; a_3 = a3;
    w_1 = w1v; w_2 = w2v; w_3 = w3v;
    b_1 = b1v; b_2 = b2v; b_3 = b3v;
  endtask

  // Present in_valid for one edge (block must be idle), then wait for
  // out_valid with a cycle budget and check the 9-cycle latency.
  task automatic accept_and_wait(input string tag);
    int cyc;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, cyc, 9);
    check({tag, ".in_ready_busy"}, {31'b0, in_ready}, 0);
  endtask

  task automatic check_outs(input string tag,
                            input logic [31:0] ew1, ew2, ew3,
                            input logic [31:0] eb1, eb2, eb3,
                            input logic [31:0] ee1, ee2, ee3,
                            input logic es);
    check({tag, ".w_new_1"}, w_new_1, ew1);
    check({tag, ".w_new_2"}, w_new_2, ew2);
    check({tag, ".w_new_3"}, w_new_3, ew3);
    check({tag, ".b_new_1"}, b_new_1, eb1);
    check({tag, ".b_new_2"}, b_new_2, eb2);
    check({tag, ".b_new_3"}, b_new_3, eb3);
    check({tag, ".err_out_1"}, err_out_1, ee1);
    check({tag, ".err_out_2"}, err_out_2, ee2);
    check({tag, ".err_out_3"}, err_out_3, ee3);
    check({tag, ".sat"}, {31'b0, sat}, {31'b0, es});
    $display("[TB] %s: w_new=(%0d,%0d,%0d) b_new=(%0d,%0d,%0d) err_out=(%0d,%0d,%0d) sat=%0b",
             tag, w_new_1, w_new_2, w_new_3, b_new_1, b_new_2, b_new_3,
             err_out_1, err_out_2, err_out_3, sat);
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".in_ready_after"}, {31'b0, in_ready}, 1);
    check({tag, ".out_valid_after"}, {31'b0, out_valid}, 0);
  endtask

  initial begin
    logic [31:0] held_w1;
    int          ov_cnt;
    int          ir_cnt;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #23;
    check("reset.in_ready", {31'b0, in_ready}, 1);
    check("reset.out_valid", {31'b0, out_valid}, 0);
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal: delta=1.0, ld=0.5
    drive(0, 65536, 32768, 65536, 131072, -65536, 65536, 0, 32768, 0, 0, 0);
    accept_and_wait("nominal");
    check_outs("nominal", 32768, -65536, 65536, -32768, -32768, -32768,
               65536, 0, 32768, 1'b0);
    handoff("nominal");

    // y=1.0 -> delta=0, everything passes through unchanged
    drive(65536, 65536, 32768, 65536, 131072, -65536, 65536, 0, 32768, 0, 0, 0);
    accept_and_wait("y_one");
    check_outs("y_one", 65536, 0, 32768, 0, 0, 0, 0, 0, 0, 1'b0);
    handoff("y_one");

    // y=1.5 -> 1-y^2 clamped to 0, no sat
    drive(98304, 65536, 32768, 65536, 131072, -65536, 65536, 0, 32768, 0, 0, 0);
    accept_and_wait("y_1p5");
    check_outs("y_1p5", 65536, 0, 32768, 0, 0, 0, 0, 0, 0, 1'b0);
    handoff("y_1p5");

    // Saturation: ld = 0x7FFFFFFF, ld*a_1 clamps, w_1 - max clamps to MIN
    drive(0, 32'h7FFFFFFF, 65536, 32'h7FFFFFFF, 0, 0, 32'h80000001, 0, 0, 0, 0, 0);
    accept_and_wait("saturate");
    check_outs("saturate", 32'h80000000, 0, 0,
               32'h80000001, 32'h80000001, 32'h80000001,
               32'h80000000, 0, 0, 1'b1);
    handoff("saturate");

    // Nominal with non-zero biases; sat must be cleared by acceptance
    drive(0, 65536, 32768, 65536, 131072, -65536, 65536, 0, 32768,
          65536, -65536, 0);
    accept_and_wait("bias");
    check_outs("bias", 32768, -65536, 65536, 32768, -98304, -32768,
               65536, 0, 32768, 1'b0);
    handoff("bias");

    // Backpressure: hold out_ready low 5 cycles, stray in_valid in the window
    drive(0, 65536, 32768, 65536, 131072, -65536, 65536, 0, 32768, 0, 0, 0);
    accept_and_wait("bp");
    held_w1 = w_new_1;
    ov_cnt = 0;
    ir_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        drive(65536, 65536, 65536, 65536, 65536, 65536, 131072, 131072,
              131072, 65536, 65536, 65536);
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid) ov_cnt++;
      if (in_ready) ir_cnt++;
    end
    check("bp.out_valid_held", ov_cnt, 5);
    check("bp.in_ready_low", ir_cnt, 0);
    check_outs("bp", 32768, -65536, 65536, -32768, -32768, -32768,
               65536, 0, 32768, 1'b0);
    handoff("bp");
    check("bp.hold_after_idle", w_new_1, held_w1);
    @(posedge clk); #1;
    check("bp.stray_not_captured", {31'b0, in_ready}, 1);

    // Reset during G2: async clear, no out_valid for the aborted job
    drive(0, 65536, 32768, 65536, 131072, -65536, 65536, 0, 32768, 0, 0, 0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.in_ready", {31'b0, in_ready}, 1);
    check("rst_mid.out_valid", {31'b0, out_valid}, 0);
    check_outs("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    #1;
    rst_n = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) ov_cnt++;
    end
    check("rst_mid.no_out_valid", ov_cnt, 0);

    // Fresh transaction after the abort
    drive(0, 65536, 32768, 65536, 131072, -65536, 65536, 0, 32768, 0, 0, 0);
    accept_and_wait("post_rst");
    check_outs("post_rst", 32768, -65536, 65536, -32768, -32768, -32768,
               65536, 0, 32768, 1'b0);
    handoff("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
